// File: rtl/matmul_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : matmul_mac_engine
// Description : Signed dot-product engine behind the matmul Wishbone slave.
//               Two-stage product/add pipeline, result held until acked.
//               Build option MATMUL_MAC_SAT_EN: clamp accumulator on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_mac_engine #(
    parameter int DW    = 32,
    parameter int LEN_W = 8,
    parameter int GUARD = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [DW-1:0]         a_i,
    input  logic [DW-1:0]         b_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    output logic [2*DW+GUARD-1:0] res_o,
    output logic                  res_valid_o,
    input  logic                  res_ack_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic                  done_irq_o
);

    localparam int c_acc_w = 2*DW + GUARD;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_acc   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]                r_state;
    logic [LEN_W-1:0]          r_cnt;
    logic signed [2*DW-1:0]    r_prod;
    logic                      r_p1_valid;
    logic                      r_p2_valid;
    logic signed [c_acc_w-1:0] r_acc;
    logic                      r_ovf;
    logic                      r_res_valid;
    logic                      r_busy;
    logic                      r_irq;

    logic                      w_accept;
    logic                      w_start;
    logic signed [c_acc_w-1:0] w_prod_ext;
    logic signed [c_acc_w-1:0] w_sum;
    logic signed [c_acc_w-1:0] w_acc_next;
    logic                      w_add_ovf;

    // Abort outranks both a pending accept and a start in the same cycle.
    assign w_accept = (r_state == c_st_acc) && (r_cnt != '0) && op_valid_i && !abort_i;
    assign w_start  = (r_state == c_st_idle) && start_i && !abort_i;

    assign w_prod_ext = c_acc_w'(r_prod);
    assign w_sum      = r_acc + w_prod_ext;
    assign w_add_ovf  = (r_acc[c_acc_w-1] == w_prod_ext[c_acc_w-1]) &&
                        (w_sum[c_acc_w-1] != r_acc[c_acc_w-1]);

`ifdef MATMUL_MAC_SAT_EN
    localparam logic signed [c_acc_w-1:0] c_acc_max = {1'b0, {(c_acc_w-1){1'b1}}};
    localparam logic signed [c_acc_w-1:0] c_acc_min = {1'b1, {(c_acc_w-1){1'b0}}};
    // Overflow direction follows the sign both addends shared.
    assign w_acc_next = w_add_ovf ? (r_acc[c_acc_w-1] ? c_acc_min : c_acc_max) : w_sum;
`else
    assign w_acc_next = w_sum;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_prod      <= '0;
            r_p1_valid  <= 1'b0;
            r_p2_valid  <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_irq      <= 1'b0;
            r_p1_valid <= w_accept;
            r_p2_valid <= r_p1_valid && !abort_i;
            if (w_accept) begin
                r_prod <= $signed(a_i) * $signed(b_i);
            end

            if (w_start) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else if (r_p1_valid && !abort_i) begin
                r_acc <= w_acc_next;
                if (w_add_ovf) begin
                    r_ovf <= 1'b1;
                end
            end

            if (abort_i) begin
                r_state     <= c_st_idle;
                r_res_valid <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start_i) begin
                            r_cnt  <= len_i;
                            r_busy <= 1'b1;
                            if (len_i == '0) begin
                                r_state     <= c_st_done;
                                r_res_valid <= 1'b1;
                                r_irq       <= 1'b1;
                            end else begin
                                r_state <= c_st_acc;
                            end
                        end
                    end
                    c_st_acc: begin
                        if (w_accept) begin
                            r_cnt <= r_cnt - 1'b1;
                            if (r_cnt == LEN_W'(1)) begin
                                r_state <= c_st_drain;
                            end
                        end
                    end
                    c_st_drain: begin
                        // Result is final only once neither stage holds work.
                        if (!r_p1_valid && !r_p2_valid) begin
                            r_state     <= c_st_done;
                            r_res_valid <= 1'b1;
                            r_irq       <= 1'b1;
                        end
                    end
                    c_st_done: begin
                        if (res_ack_i) begin
                            r_state     <= c_st_idle;
                            r_res_valid <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    assign op_ready_o  = (r_state == c_st_acc) && (r_cnt != '0);
    assign res_o       = r_acc;
    assign res_valid_o = r_res_valid;
    assign busy_o      = r_busy;
    assign ovf_o       = r_ovf;
    assign done_irq_o  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_matmul_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_mac_engine
// Description : Directed bench for matmul_mac_engine with a result scoreboard;
//               a second GUARD=0 instance exercises the overflow path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_mac_engine;

    localparam int DW    = 32;
    localparam int LEN_W = 8;
    localparam int GUARD = 8;
    localparam int ACC_W = 2*DW + GUARD;
    localparam int G0_W  = 2*DW;

`ifdef MATMUL_MAC_SAT_EN
    localparam logic [G0_W-1:0] c_g0_ovf_res = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    localparam logic [G0_W-1:0] c_g0_ovf_res = 64'h8000_0000_0000_0000;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             abort_i;
    logic [LEN_W-1:0] len_i;
    logic [DW-1:0]    a_i;
    logic [DW-1:0]    b_i;
    logic             op_valid_i;
    logic             res_ack_i;

    logic             op_ready_o;
    logic [ACC_W-1:0] res_o;
    logic             res_valid_o;
    logic             busy_o;
    logic             ovf_o;
    logic             done_irq_o;

    logic             g0_op_ready;
    logic [G0_W-1:0]  g0_res;
    logic             g0_res_valid;
    logic             g0_busy;
    logic             g0_ovf;
    logic             g0_irq;

    logic [ACC_W-1:0] exp_q[$];
    int               n_pass  = 0;
    int               n_total = 0;

    always #5 clk = ~clk;

    matmul_mac_engine #(.DW(DW), .LEN_W(LEN_W), .GUARD(GUARD)) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .len_i       (len_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_ack_i   (res_ack_i),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o),
        .done_irq_o  (done_irq_o)
    );

    matmul_mac_engine #(.DW(DW), .LEN_W(LEN_W), .GUARD(0)) u_dut_g0 (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .len_i       (len_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (g0_op_ready),
        .res_o       (g0_res),
        .res_valid_o (g0_res_valid),
        .res_ack_i   (res_ack_i),
        .busy_o      (g0_busy),
        .ovf_o       (g0_ovf),
        .done_irq_o  (g0_irq)
    );

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int len);
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        step();
        start_i = 1'b0;
    endtask

    task automatic send_pair(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit got;
        got        = 1'b0;
        a_i        = a;
        b_i        = b;
        op_valid_i = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = op_ready_o;
            step();
        end
        check({tag, "_accept"}, ACC_W'(got), ACC_W'(1));
    endtask

    task automatic wait_result(input string tag);
        bit               seen;
        logic [ACC_W-1:0] e;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (res_valid_o) seen = 1'b1;
            else step();
        end
        check({tag, "_valid"}, ACC_W'(seen), ACC_W'(1));
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check({tag, "_res"}, res_o, e);
    endtask

    task automatic ack_result();
        step();
        res_ack_i = 1'b1;
        step();
        res_ack_i = 1'b0;
    endtask

    initial begin
        logic bad;
        rst        = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        len_i      = '0;
        a_i        = '0;
        b_i        = '0;
        op_valid_i = 1'b0;
        res_ack_i  = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        check("rst_res", res_o, '0);
        check("rst_flags", ACC_W'({res_valid_o, busy_o, ovf_o, done_irq_o, op_ready_o}), '0);
        step();
        rst = 1'b0;
        step();

        // Basic back-to-back run: 6 - 20 - 7 = -21
        start_run(3);
        exp_q.push_back(-72'sd21);
        send_pair("basic_p0", 32'd2, 32'd3);
        send_pair("basic_p1", -32'sd4, 32'd5);
        send_pair("basic_p2", 32'd7, -32'sd1);
        op_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("basic_lat%0d", k), ACC_W'(res_valid_o), '0);
            step();
        end
        wait_result("basic");
        check("basic_irq", ACC_W'(done_irq_o), ACC_W'(1));
        check("basic_busy", ACC_W'(busy_o), ACC_W'(1));
        step();
        @(negedge clk);
        check("basic_irq_pulse", ACC_W'(done_irq_o), '0);
        check("basic_hold", ACC_W'(res_valid_o), ACC_W'(1));
        check("basic_hold_res", res_o, -72'sd21);
        ack_result();
        @(negedge clk);
        check("basic_after_ack", ACC_W'({res_valid_o, busy_o, ovf_o}), '0);
        step();

        // Backpressure: gapped pairs, -300 + 3000 = 2700
        start_run(2);
        exp_q.push_back(72'd2700);
        send_pair("bp_p0", 32'd100, -32'sd3);
        op_valid_i = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bad = bad | ~op_ready_o;
            step();
        end
        check("bp_ready_in_gap", ACC_W'(bad), '0);
        send_pair("bp_p1", -32'sd50, -32'sd60);
        op_valid_i = 1'b0;
        @(negedge clk);
        check("bp_ready_after_last", ACC_W'(op_ready_o), '0);
        wait_result("bp");
        ack_result();

        // Zero-length run, start during DONE ignored, start with ack ignored
        start_run(0);
        exp_q.push_back('0);
        @(negedge clk);
        check("len0_valid", ACC_W'(res_valid_o), ACC_W'(1));
        check("len0_irq", ACC_W'(done_irq_o), ACC_W'(1));
        check("len0_res", res_o, exp_q.pop_front());
        step();
        start_i = 1'b1;
        len_i   = 8'd3;
        step();
        @(negedge clk);
        check("len0_start_ignored", ACC_W'({res_valid_o, done_irq_o, op_ready_o}), ACC_W'(3'b100));
        step();
        res_ack_i = 1'b1;
        step();
        res_ack_i = 1'b0;
        start_i   = 1'b0;
        @(negedge clk);
        check("len0_ack_wins", ACC_W'({busy_o, res_valid_o, op_ready_o}), '0);
        step();

        // Abort after two accepts, with start and a valid pair in the same cycle
        start_run(4);
        send_pair("ab_p0", 32'd1, 32'd1);
        send_pair("ab_p1", 32'd2, 32'd2);
        a_i        = 32'd3;
        b_i        = 32'd3;
        abort_i    = 1'b1;
        start_i    = 1'b1;
        len_i      = 8'd1;
        step();
        abort_i    = 1'b0;
        start_i    = 1'b0;
        op_valid_i = 1'b0;
        bad        = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bad = bad | done_irq_o | res_valid_o | busy_o | op_ready_o;
            step();
        end
        check("abort_quiet", ACC_W'(bad), '0);
        start_run(2);
        exp_q.push_back(72'd28);
        send_pair("clean_p0", 32'd5, 32'd6);
        send_pair("clean_p1", -32'sd1, 32'd2);
        op_valid_i = 1'b0;
        wait_result("clean");
        ack_result();

        // Overflow: 2 * 2^62 = 2^63 fits 72 bits, overflows 64 bits
        start_run(2);
        exp_q.push_back(72'h00_8000_0000_0000_0000);
        send_pair("ovf_p0", 32'h8000_0000, 32'h8000_0000);
        send_pair("ovf_p1", 32'h8000_0000, 32'h8000_0000);
        op_valid_i = 1'b0;
        wait_result("ovf");
        check("ovf_main_flag", ACC_W'(ovf_o), '0);
        check("ovf_g0_valid", ACC_W'(g0_res_valid), ACC_W'(1));
        check("ovf_g0_res", ACC_W'(g0_res), ACC_W'(c_g0_ovf_res));
        check("ovf_g0_flag", ACC_W'(g0_ovf), ACC_W'(1));
        ack_result();
        @(negedge clk);
        check("ovf_g0_sticky", ACC_W'(g0_ovf), ACC_W'(1));
        step();
        start_run(0);
        exp_q.push_back('0);
        wait_result("ovf_clear");
        check("ovf_g0_cleared", ACC_W'(g0_ovf), '0);
        ack_result();

        // Reset mid-ACC after two accepts
        start_run(5);
        send_pair("rst_p0", 32'd3, 32'd4);
        send_pair("rst_p1", 32'd5, 32'd6);
        rst = 1'b1;
        #1;
        check("midrst_res", res_o, '0);
        check("midrst_flags", ACC_W'({res_valid_o, busy_o, ovf_o, done_irq_o, op_ready_o}), '0);
        op_valid_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        check("midrst_idle", ACC_W'({busy_o, op_ready_o, res_valid_o}), '0);

        check("scoreboard_empty", ACC_W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
